// File: rtl/feature_map_reader.sv
// feature_map_reader: burst read controller for the feature map RAM.
// Issues strided reads, absorbs the 1-cycle RAM latency and presents the
// words on a valid/ready stream without dropping or duplicating any word.
module feature_map_reader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DOUT_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] fmr_addrb,
    output logic                  fmr_enb,
    input  logic [DOUT_WIDTH-1:0] fmr_doutb,
    output logic [DOUT_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned BUF_DEPTH = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_enb;
    logic [ADDR_WIDTH-1:0] r_addrb;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [CNT_WIDTH-1:0]  r_issue_left;
    logic [CNT_WIDTH-1:0]  r_pop_left;

    // Output buffer: entry 0 is the stream head. Two entries back the
    // issue rule; the third holds the read already on the RAM bus when the
    // consumer stalls right after an issue.
    logic [DOUT_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [1:0]            r_occ;
    logic                  r_valid;
    logic                  r_dv;

    logic       w_pop;
    logic [2:0] w_occ_after;
    logic [1:0] w_widx;
    logic       w_space;
    logic       w_issue;

    assign w_pop       = r_valid & out_ready;
    assign w_occ_after = 3'(r_occ) + 3'(r_dv) - 3'(w_pop);
    assign w_widx      = r_occ - 2'(w_pop);
    // Issue only if the buffer, after this cycle's capture and pop, holds
    // fewer than two words.
    assign w_space     = (w_occ_after < 3'd2);
    assign w_issue     = (r_state == S_READ) && (r_issue_left != '0) && w_space;

    // Command FSM: accepts bursts, drives the RAM read port, tracks completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_enb        <= 1'b0;
            r_addrb      <= '0;
            r_next_addr  <= '0;
            r_stride     <= '0;
            r_issue_left <= '0;
            r_pop_left   <= '0;
        end else begin
            r_done <= 1'b0;
            r_enb  <= 1'b0;
            if (w_pop) begin
                r_pop_left <= r_pop_left - CNT_WIDTH'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_stride <= stride;
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy       <= 1'b1;
                            r_enb        <= 1'b1;
                            r_addrb      <= base_addr;
                            r_next_addr  <= base_addr + stride;
                            r_issue_left <= count - CNT_WIDTH'(1);
                            r_pop_left   <= count;
                            r_state      <= (count == CNT_WIDTH'(1)) ? S_DRAIN : S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_enb        <= 1'b1;
                        r_addrb      <= r_next_addr;
                        r_next_addr  <= r_next_addr + r_stride;
                        r_issue_left <= r_issue_left - CNT_WIDTH'(1);
                        if (r_issue_left == CNT_WIDTH'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (r_pop_left == CNT_WIDTH'(1))) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO: shift on pop, capture returning RAM data behind the
    // surviving entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_occ   <= '0;
            r_valid <= 1'b0;
            r_dv    <= 1'b0;
        end else begin
            r_dv <= r_enb;
            if (w_pop) begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                    r_buf[i] <= r_buf[i+1];
                end
            end
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (r_dv && (w_widx == 2'(i))) begin
                    r_buf[i] <= fmr_doutb;
                end
            end
            r_occ   <= w_occ_after[1:0];
            r_valid <= (w_occ_after != 3'd0);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign fmr_enb   = r_enb;
    assign fmr_addrb = r_addrb;
    assign out_data  = r_buf[0];
    assign out_valid = r_valid;

endmodule

// File: tb/tb_feature_map_reader.sv
// Directed bench for feature_map_reader with a 1-cycle-latency RAM model.
module tb_feature_map_reader;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 128;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
    logic [AW-1:0] fmr_addrb;
    logic          fmr_enb;
    logic [DW-1:0] fmr_doutb;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:1023];

    always #5 clk = ~clk;

    // RAM model: data valid the cycle after the enable.
    always_ff @(posedge clk) begin
        if (fmr_enb) fmr_doutb <= mem[fmr_addrb];
    end

    feature_map_reader #(.ADDR_WIDTH(AW), .DOUT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .stride(stride), .count(count), .busy(busy), .done(done),
        .fmr_addrb(fmr_addrb), .fmr_enb(fmr_enb), .fmr_doutb(fmr_doutb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; count = '0; out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks += 6;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        if (fmr_enb !== 1'b0)   begin errors++; $display("FAIL reset_enb got=%0b exp=0", fmr_enb); end
        if (fmr_addrb !== '0)   begin errors++; $display("FAIL reset_addrb got=%0d exp=0", fmr_addrb); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_w [3];
        logic exp_enb, exp_valid;
        exp_w[0] = DW'(16'h4000); exp_w[1] = DW'(16'h4200); exp_w[2] = DW'(16'h4600);
        for (int i = 0; i < 3; i++) mem[i] = exp_w[i];
        start = 1'b1; base_addr = 10'd0; stride = 10'd1; count = 16'd3; out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_enb   = (c >= 1 && c <= 3);
            exp_valid = (c >= 3 && c <= 5);
            checks += 4;
            if (fmr_enb !== exp_enb) begin errors++; $display("FAIL basic_enb c=%0d got=%0b exp=%0b", c, fmr_enb, exp_enb); end
            if (out_valid !== exp_valid) begin errors++; $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, out_valid, exp_valid); end
            if (done !== (c == 6)) begin errors++; $display("FAIL basic_done c=%0d got=%0b", c, done); end
            if (busy !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL basic_busy c=%0d got=%0b", c, busy); end
            if (exp_enb) begin
                checks++;
                if (fmr_addrb !== AW'(c - 1)) begin errors++; $display("FAIL basic_addr c=%0d got=%0d exp=%0d", c, fmr_addrb, c - 1); end
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== exp_w[c-3]) begin errors++; $display("FAIL basic_data c=%0d got=%0h exp=%0h", c, out_data, exp_w[c-3]); end
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_w [3];
        int pat [6];
        int landed, popped, occ, nout, ndone;
        logic e1, pop, prev_stall;
        logic [DW-1:0] prev_data;
        pat = '{1, 0, 0, 1, 0, 1};
        exp_w[0] = DW'(16'h4000); exp_w[1] = DW'(16'h4200); exp_w[2] = DW'(16'h4600);
        for (int i = 0; i < 3; i++) mem[i] = exp_w[i];
        landed = 0; popped = 0; nout = 0; ndone = 0; e1 = 1'b0; prev_stall = 1'b0; prev_data = '0;
        start = 1'b1; base_addr = 10'd0; stride = 10'd1; count = 16'd3; out_ready = pat[0][0];
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            occ = landed - popped;
            pop = out_valid && out_ready;
            checks += 2;
            if (out_valid !== (occ > 0)) begin errors++; $display("FAIL bp_valid c=%0d got=%0b occ=%0d", c, out_valid, occ); end
            if (fmr_enb && occ >= 2 && !pop) begin errors++; $display("FAIL bp_overissue c=%0d enb=%0b occ=%0d", c, fmr_enb, occ); end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++; $display("FAIL bp_stable c=%0d got=%0h/%0b exp=%0h/1", c, out_data, out_valid, prev_data);
                end
            end
            if (pop) begin
                checks++;
                if (nout >= 3) begin errors++; $display("FAIL bp_extra c=%0d got=%0h exp=none", c, out_data); end
                else if (out_data !== exp_w[nout]) begin errors++; $display("FAIL bp_order c=%0d got=%0h exp=%0h", c, out_data, exp_w[nout]); end
                nout++;
            end
            if (done) ndone++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            landed += int'(e1);
            e1 = fmr_enb;
            popped += int'(pop);
            tick();
            start = 1'b0;
            out_ready = pat[(c + 1) % 6][0];
        end
        checks += 3;
        if (nout != 3)  begin errors++; $display("FAIL bp_count got=%0d exp=3", nout); end
        if (ndone != 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", ndone); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got=%0b exp=0", busy); end
    endtask

    task automatic test_count_zero();
        start = 1'b1; base_addr = 10'd7; stride = 10'd1; count = 16'd0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks += 3;
            if (done !== (c == 1)) begin errors++; $display("FAIL zero_done c=%0d got=%0b", c, done); end
            if (fmr_enb !== 1'b0)  begin errors++; $display("FAIL zero_enb c=%0d got=%0b exp=0", c, fmr_enb); end
            if (busy !== 1'b0)     begin errors++; $display("FAIL zero_busy c=%0d got=%0b exp=0", c, busy); end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_wrap_ignored_start();
        logic [AW-1:0] exp_a [4];
        logic [DW-1:0] exp_w [4];
        exp_a = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        exp_w[0] = DW'(16'hA001); exp_w[1] = DW'(16'hA002); exp_w[2] = DW'(16'hA003); exp_w[3] = DW'(16'hA004);
        for (int i = 0; i < 4; i++) mem[exp_a[i]] = exp_w[i];
        start = 1'b1; base_addr = 10'd1022; stride = 10'd1; count = 16'd4; out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            checks += 4;
            if (fmr_enb !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL wrap_enb c=%0d got=%0b", c, fmr_enb); end
            if (out_valid !== (c >= 3 && c <= 6)) begin errors++; $display("FAIL wrap_valid c=%0d got=%0b", c, out_valid); end
            if (done !== (c == 7)) begin errors++; $display("FAIL wrap_done c=%0d got=%0b", c, done); end
            if (busy !== (c >= 1 && c <= 6)) begin errors++; $display("FAIL wrap_busy c=%0d got=%0b", c, busy); end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (fmr_addrb !== exp_a[c-1]) begin errors++; $display("FAIL wrap_addr c=%0d got=%0d exp=%0d", c, fmr_addrb, exp_a[c-1]); end
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (out_data !== exp_w[c-3]) begin errors++; $display("FAIL wrap_data c=%0d got=%0h exp=%0h", c, out_data, exp_w[c-3]); end
            end
            tick();
            // Second start mid-burst with different parameters must be ignored.
            if (c + 1 == 2) begin
                start = 1'b1; base_addr = 10'd5; stride = 10'd3; count = 16'd7;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 10; i++) mem[100 + 2*i] = DW'(16'hB000 + 16'(i));
        mem[200] = DW'(16'hC0DE); mem[203] = DW'(16'hC0DF);
        start = 1'b1; base_addr = 10'd100; stride = 10'd2; count = 16'd10; out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 4) begin
                checks += 2;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL rstm_pre_valid got=%0b exp=1", out_valid); end
                if (out_data !== mem[100]) begin errors++; $display("FAIL rstm_pre_data got=%0h exp=%0h", out_data, mem[100]); end
            end
            if (c == 5) begin
                checks += 4;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_valid got=%0b exp=0", out_valid); end
                if (fmr_enb !== 1'b0)   begin errors++; $display("FAIL rstm_enb got=%0b exp=0", fmr_enb); end
                if (busy !== 1'b0)      begin errors++; $display("FAIL rstm_busy got=%0b exp=0", busy); end
                if (out_data !== '0)    begin errors++; $display("FAIL rstm_data got=%0h exp=0", out_data); end
            end
            if (c >= 5) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL rstm_done c=%0d got=%0b exp=0", c, done); end
            end
            tick();
            start = 1'b0;
            rst = (c + 1 == 4);
        end
        rst = 1'b0;
        start = 1'b1; base_addr = 10'd200; stride = 10'd3; count = 16'd2; out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks += 3;
            if (fmr_enb !== (c == 1 || c == 2)) begin errors++; $display("FAIL rstm2_enb c=%0d got=%0b", c, fmr_enb); end
            if (out_valid !== (c == 3 || c == 4)) begin errors++; $display("FAIL rstm2_valid c=%0d got=%0b", c, out_valid); end
            if (done !== (c == 5)) begin errors++; $display("FAIL rstm2_done c=%0d got=%0b", c, done); end
            if (c == 1 || c == 2) begin
                checks++;
                if (fmr_addrb !== AW'(200 + 3*(c-1))) begin errors++; $display("FAIL rstm2_addr c=%0d got=%0d exp=%0d", c, fmr_addrb, 200 + 3*(c-1)); end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (out_data !== mem[200 + 3*(c-3)]) begin errors++; $display("FAIL rstm2_data c=%0d got=%0h exp=%0h", c, out_data, mem[200 + 3*(c-3)]); end
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic exp_enb, exp_valid;
        int a_idx;
        mem[10] = DW'(16'hD010); mem[11] = DW'(16'hD011);
        mem[20] = DW'(16'hD020); mem[21] = DW'(16'hD021);
        start = 1'b1; base_addr = 10'd10; stride = 10'd1; count = 16'd2; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_enb   = (c == 1 || c == 2 || c == 6 || c == 7);
            exp_valid = (c == 3 || c == 4 || c == 8 || c == 9);
            checks += 4;
            if (fmr_enb !== exp_enb) begin errors++; $display("FAIL b2b_enb c=%0d got=%0b exp=%0b", c, fmr_enb, exp_enb); end
            if (out_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid c=%0d got=%0b exp=%0b", c, out_valid, exp_valid); end
            if (done !== (c == 5 || c == 10)) begin errors++; $display("FAIL b2b_done c=%0d got=%0b", c, done); end
            if (busy !== ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))) begin errors++; $display("FAIL b2b_busy c=%0d got=%0b", c, busy); end
            if (exp_enb) begin
                a_idx = (c <= 2) ? (10 + c - 1) : (20 + c - 6);
                checks++;
                if (fmr_addrb !== AW'(a_idx)) begin errors++; $display("FAIL b2b_addr c=%0d got=%0d exp=%0d", c, fmr_addrb, a_idx); end
            end
            if (exp_valid) begin
                a_idx = (c <= 4) ? (10 + c - 3) : (20 + c - 8);
                checks++;
                if (out_data !== mem[a_idx]) begin errors++; $display("FAIL b2b_data c=%0d got=%0h exp=%0h", c, out_data, mem[a_idx]); end
            end
            tick();
            if (c + 1 == 5) begin
                start = 1'b1; base_addr = 10'd20; stride = 10'd1; count = 16'd2;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_basic();
        repeat (2) tick();
        test_backpressure();
        repeat (2) tick();
        test_count_zero();
        repeat (2) tick();
        test_wrap_ignored_start();
        repeat (2) tick();
        test_reset_mid_burst();
        repeat (2) tick();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
